wm_mul_fu_ctrl: RTL and testbench
=================================

// Module: wm_mul_fu_ctrl
// PURPOSE
//  Sequencer for the 16x16 Wallace-tree multiplier functional unit in the scoreboard pipeline.
//  - Accepts one multiply from scoreboard issue and drives registered operands into the CSA reduction tree.
//  - Waits TREE_CYC cycles, then latches the tree sum/carry vectors and resolves them with a 32-bit carry-propagate add.
//  - Holds the result and destination tag until write-back grants it. Single op in flight; busy feeds the FU status table.
// PARAMETERS
//  TREE_CYC  2   cycles allowed for the CSA tree to settle; legal range 1..15
//  TAG_W     4   destination-register tag width
//  COUNT_W   16  width of the completed-op counter
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst          in   1        synchronous, active-high reset
//  flush        in   1        squash the in-flight op (branch/exception recovery)
//  issue_valid  in   1        scoreboard presents a multiply
//  issue_ready  out  1        FU can accept; high only in IDLE and only while rst=0
//  issue_tag    in   TAG_W    destination tag of the issued op
//  issue_a      in   16       multiplicand, unsigned
//  issue_b      in   16       multiplier, unsigned
//  mul_a        out  16       registered operand A to the CSA tree
//  mul_b        out  16       registered operand B to the CSA tree
//  tree_u       in   32       tree final sum vector, bit-aligned to the product
//  tree_v       in   32       tree final carry vector, bit-aligned to the product; unused MSBs tied 0
//  busy         out  1        op in flight (state != IDLE)
//  wb_req       out  1        result valid, requesting write-back
//  wb_tag       out  TAG_W    tag of the result
//  wb_result    out  32       product
//  wb_ack       in   1        write-back grant; handshake completes when wb_req & wb_ack
//  op_count     out  COUNT_W  completed multiplies, wraps modulo 2^COUNT_W
// BEHAVIOUR
//  Reset: state=IDLE; mul_a, mul_b, wb_tag, wb_result, op_count, tree-capture regs and down-counter all 0.
//   wb_req=0, busy=0, issue_ready=0 while rst is high.
//  FSM states: IDLE -> TREE -> ADD -> WB -> IDLE
//  - IDLE: issue_ready=1. On issue_valid: latch issue_a/b into mul_a/b, latch tag, cnt=TREE_CYC-1, go to TREE.
//  - TREE: if cnt!=0, decrement cnt. If cnt==0, capture tree_u/tree_v and go to ADD. TREE lasts exactly TREE_CYC cycles.
//  - ADD: wb_result <= (u_cap + v_cap) mod 2^32, carry-out discarded. Set wb_req=1 and go to WB.
//  - WB: wb_req, wb_tag, wb_result and mul_a/b are held stable.
//    On wb_ack: wb_req=0, op_count+1 (wraps), go to IDLE.
//  Latency: accept at edge E gives wb_req high from edge E+TREE_CYC+1.
//   Minimum issue-to-issue interval is TREE_CYC+3 cycles when wb_ack is immediate.
//  issue_valid outside IDLE is ignored; no state change.
//  wb_ack while wb_req=0 is ignored.
//  mul_a/b are unchanged until the next accept. Results are data-independent of stale tree outputs outside TREE.
//  Priority: rst > flush > wb_ack / issue.
//  flush (any state) gives state=IDLE and wb_req=0 at the next edge, with op_count unchanged.
//   A flush coincident with wb_ack cancels the write-back and does not count it.
//   A flush in IDLE coincident with issue_valid is not an accept.
//  Reset mid-op: abandon the op immediately. No write-back, op_count cleared.
// STRUCTURE
//  Shared package wm_defs: FSM state encoding (2-bit IDLE/TREE/ADD/WB), WM_OP_W=16, WM_PROD_W=32.
//  One sub-module: wm_cpa32, a combinational 32-bit adder (a, b -> s, cout), instanced in the ADD path.
//  CSA tree is instantiated by the parent; this block only drives and samples it.
// TESTING (TREE_CYC=2 unless noted; bench models the tree as u/v from a golden split)
//  1. rst high 2 cycles mid-TREE -> wb_req=0, busy=0, issue_ready=0 during rst, op_count=0, state IDLE after.
//  2. issue a=0x00FF b=0x0101 tag=3 at E; tree_u=0x0000F0F0, tree_v=0x00000F0F
//     -> wb_req high from E+3, wb_result=0x0000FFFF, wb_tag=3. Ack at E+3 gives op_count=1.
//  3. a=b=0xFFFF with u=0xFFFE0000, v=0x00000001 -> 0xFFFE0001.
//     Forced u=0xFFFFFFFF, v=0x2 -> 0x00000001 (carry-out dropped).
//  4. wb_ack held low 5 cycles, issue_valid pulsed -> wb_req/tag/result stable, issue_ready=0, second op not accepted.
//  5. flush during TREE, then flush together with wb_ack in WB -> IDLE next edge, no write-back, op_count unchanged.
//  6. COUNT_W=4, TREE_CYC=1: 16 back-to-back ops with immediate ack
//     -> op_count wraps to 0, each accept exactly 4 cycles apart.

Source files
------------

// File: rtl/wm_defs.sv
// Shared definitions for the Wallace-tree multiplier FU sequencer.
// Holds the FSM state encoding and the operand/product widths.
package wm_defs;

    localparam int WM_OP_W   = 16;
    localparam int WM_PROD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TREE = 2'd1,
        ST_ADD  = 2'd2,
        ST_WB   = 2'd3
    } wm_state_e;

endpackage

// File: rtl/wm_cpa32.sv
// Combinational 32-bit carry-propagate adder.
// Resolves the CSA tree sum/carry vectors into the final product.
module wm_cpa32
    import wm_defs::*;
(
    input  logic [WM_PROD_W-1:0] a,
    input  logic [WM_PROD_W-1:0] b,
    output logic [WM_PROD_W-1:0] s,
    output logic                 cout
);

    logic [WM_PROD_W:0] sum_full;

    // Widen by one bit so the carry-out is kept separate from the sum
    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b};
        s        = sum_full[WM_PROD_W-1:0];
        cout     = sum_full[WM_PROD_W];
    end

endmodule

// File: rtl/wm_mul_fu_ctrl.sv
// Sequencer for the 16x16 Wallace-tree multiplier functional unit.
// Issues operands to the CSA tree, resolves the result, holds it for write-back.
module wm_mul_fu_ctrl
    import wm_defs::*;
#(
    parameter int TREE_CYC = 2,
    parameter int TAG_W    = 4,
    parameter int COUNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [TAG_W-1:0]     issue_tag,
    input  logic [WM_OP_W-1:0]   issue_a,
    input  logic [WM_OP_W-1:0]   issue_b,
    output logic [WM_OP_W-1:0]   mul_a,
    output logic [WM_OP_W-1:0]   mul_b,
    input  logic [WM_PROD_W-1:0] tree_u,
    input  logic [WM_PROD_W-1:0] tree_v,
    output logic                 busy,
    output logic                 wb_req,
    output logic [TAG_W-1:0]     wb_tag,
    output logic [WM_PROD_W-1:0] wb_result,
    input  logic                 wb_ack,
    output logic [COUNT_W-1:0]   op_count
);

    localparam logic [3:0] CNT_INIT = 4'(TREE_CYC - 1);

    wm_state_e            state_q;
    logic [3:0]           cnt_q;
    logic [WM_OP_W-1:0]   mul_a_q;
    logic [WM_OP_W-1:0]   mul_b_q;
    logic [TAG_W-1:0]     tag_q;
    logic [WM_PROD_W-1:0] u_cap_q;
    logic [WM_PROD_W-1:0] v_cap_q;
    logic [WM_PROD_W-1:0] result_q;
    logic                 wb_req_q;
    logic [COUNT_W-1:0]   op_count_q;

    logic [WM_PROD_W-1:0] sum_d;
    logic                 cpa_unused_cout;

    // Product is formed only from the captured vectors, never live tree outputs
    wm_cpa32 u_cpa (
        .a    (u_cap_q),
        .b    (v_cap_q),
        .s    (sum_d),
        .cout (cpa_unused_cout)
    );

    // Sequencer: IDLE -> TREE -> ADD -> WB -> IDLE, flush returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            tag_q      <= '0;
            u_cap_q    <= '0;
            v_cap_q    <= '0;
            result_q   <= '0;
            wb_req_q   <= 1'b0;
            op_count_q <= '0;
        end else if (flush) begin
            state_q  <= ST_IDLE;
            wb_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (issue_valid) begin
                        mul_a_q <= issue_a;
                        mul_b_q <= issue_b;
                        tag_q   <= issue_tag;
                        cnt_q   <= CNT_INIT;
                        state_q <= ST_TREE;
                    end
                end
                ST_TREE: begin
                    if (cnt_q == 4'd0) begin
                        u_cap_q <= tree_u;
                        v_cap_q <= tree_v;
                        state_q <= ST_ADD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ADD: begin
                    result_q <= sum_d;
                    wb_req_q <= 1'b1;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    if (wb_ack) begin
                        wb_req_q   <= 1'b0;
                        op_count_q <= op_count_q + COUNT_W'(1);
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready must drop with reset even though the state is already IDLE
    always_comb begin
        issue_ready = (state_q == ST_IDLE) && !rst;
        busy        = (state_q != ST_IDLE);
        mul_a       = mul_a_q;
        mul_b       = mul_b_q;
        wb_req      = wb_req_q;
        wb_tag      = tag_q;
        wb_result   = result_q;
        op_count    = op_count_q;
    end

endmodule

// File: tb/tb_wm_mul_fu_ctrl.sv
// Directed self-checking bench for wm_mul_fu_ctrl.
// Instance u0 uses defaults; u1 uses TREE_CYC=1, COUNT_W=4 for wrap/throughput.
module tb_wm_mul_fu_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // u0 signals
    logic        flush0, iv0, ir0, busy0, req0, ack0;
    logic [3:0]  itag0, wtag0;
    logic [15:0] ia0, ib0, ma0, mb0;
    logic [31:0] tu0, tv0, res0;
    logic [15:0] cnt0;

    // u1 signals
    logic        flush1, iv1, ir1, busy1, req1, ack1;
    logic [3:0]  itag1, wtag1;
    logic [15:0] ia1, ib1, ma1, mb1;
    logic [31:0] tu1, tv1, res1;
    logic [3:0]  cnt1;

    wm_mul_fu_ctrl u0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .issue_valid(iv0), .issue_ready(ir0), .issue_tag(itag0),
        .issue_a(ia0), .issue_b(ib0), .mul_a(ma0), .mul_b(mb0),
        .tree_u(tu0), .tree_v(tv0), .busy(busy0),
        .wb_req(req0), .wb_tag(wtag0), .wb_result(res0),
        .wb_ack(ack0), .op_count(cnt0)
    );

    wm_mul_fu_ctrl #(.TREE_CYC(1), .TAG_W(4), .COUNT_W(4)) u1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .issue_valid(iv1), .issue_ready(ir1), .issue_tag(itag1),
        .issue_a(ia1), .issue_b(ib1), .mul_a(ma1), .mul_b(mb1),
        .tree_u(tu1), .tree_v(tv1), .busy(busy1),
        .wb_req(req1), .wb_tag(wtag1), .wb_result(res1),
        .wb_ack(ack1), .op_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op to u0 for a single accept edge
    task automatic issue0(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] t, input logic [31:0] u,
                          input logic [31:0] v);
        ia0 = a; ib0 = b; itag0 = t; tu0 = u; tv0 = v;
        iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
    endtask

    int last_acc;
    int acc;
    int n;
    logic [31:0] prod;

    initial begin
        rst = 1'b1;
        flush0 = 0; iv0 = 0; ack0 = 0; itag0 = 0; ia0 = 0; ib0 = 0;
        tu0 = 0; tv0 = 0;
        flush1 = 0; iv1 = 0; ack1 = 0; itag1 = 0; ia1 = 0; ib1 = 0;
        tu1 = 0; tv1 = 0;
        tick();
        tick();
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_ready", 32'(ir0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_res", res0, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(ir0), 32'd1);

        // 1: reset mid-TREE
        issue0(16'h1234, 16'h0002, 4'd7, 32'h1, 32'h2);
        chk("t1_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        chk("t1_ready_rst", 32'(ir0), 32'd0);
        tick();
        chk("t1_busy_rst", 32'(busy0), 32'd0);
        chk("t1_req_rst", 32'(req0), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t1_ready", 32'(ir0), 32'd1);
        chk("t1_cnt", 32'(cnt0), 32'd0);
        chk("t1_mula", 32'(ma0), 32'd0);

        // 2: basic op, latency E+3
        issue0(16'h00FF, 16'h0101, 4'd3, 32'h0000F0F0, 32'h00000F0F);
        chk("t2_mula", 32'(ma0), 32'h00FF);
        chk("t2_mulb", 32'(mb0), 32'h0101);
        chk("t2_ready", 32'(ir0), 32'd0);
        tick();
        tick();
        chk("t2_req_early", 32'(req0), 32'd0);
        tick();
        chk("t2_req", 32'(req0), 32'd1);
        chk("t2_res", res0, 32'h0000FFFF);
        chk("t2_tag", 32'(wtag0), 32'd3);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("t2_req_off", 32'(req0), 32'd0);
        chk("t2_cnt", 32'(cnt0), 32'd1);
        chk("t2_busy", 32'(busy0), 32'd0);

        // 3: full-scale op and dropped carry; tree goes stale after capture
        issue0(16'hFFFF, 16'hFFFF, 4'd9, 32'hFFFE0000, 32'h00000001);
        tick();
        tick();
        tu0 = 32'hDEADBEEF; tv0 = 32'h55555555;
        tick();
        chk("t3_res", res0, 32'hFFFE0001);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        issue0(16'h0001, 16'h0001, 4'd1, 32'hFFFFFFFF, 32'h00000002);
        tick();
        tick();
        tick();
        chk("t3_wrapres", res0, 32'h00000001);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("t3_cnt", 32'(cnt0), 32'd3);

        // 4: stall in WB, stray issues ignored
        issue0(16'hABCD, 16'h0003, 4'd5, 32'h12345678, 32'h11111111);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            ia0 = 16'h9999; itag0 = 4'd12;
            iv0 = (i % 2 == 0);
            tick();
            chk("t4_req", 32'(req0), 32'd1);
            chk("t4_res", res0, 32'h23456789);
            chk("t4_tag", 32'(wtag0), 32'd5);
            chk("t4_ready", 32'(ir0), 32'd0);
            chk("t4_mula", 32'(ma0), 32'hABCD);
        end
        iv0 = 1'b0;
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("t4_cnt", 32'(cnt0), 32'd4);
        chk("t4_idle", 32'(busy0), 32'd0);
        tick();
        chk("t4_noacc", 32'(busy0), 32'd0);

        // 5: flush in TREE, flush with ack in WB, flush with issue in IDLE
        issue0(16'h0010, 16'h0010, 4'd2, 32'h100, 32'h0);
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        chk("t5_tree_busy", 32'(busy0), 32'd0);
        chk("t5_tree_req", 32'(req0), 32'd0);
        issue0(16'h0010, 16'h0010, 4'd2, 32'h100, 32'h0);
        tick();
        tick();
        tick();
        chk("t5_wb_req", 32'(req0), 32'd1);
        flush0 = 1'b1;
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("t5_wb_req_off", 32'(req0), 32'd0);
        chk("t5_wb_busy", 32'(busy0), 32'd0);
        chk("t5_cnt", 32'(cnt0), 32'd4);
        iv0 = 1'b1; ia0 = 16'h7777;
        tick();
        iv0 = 1'b0;
        flush0 = 1'b0;
        chk("t5_idle_busy", 32'(busy0), 32'd0);
        chk("t5_idle_mula", 32'(ma0), 32'h0010);

        // 6: TREE_CYC=1, COUNT_W=4 back-to-back
        last_acc = 0;
        for (int k = 0; k < 16; k++) begin
            n = 0;
            while (!ir1 && n < 20) begin
                tick();
                n++;
            end
            chk("t6_ready_to", 32'(n < 20), 32'd1);
            ia1 = 16'(k * 37 + 5);
            ib1 = 16'(k * 11 + 3);
            prod = 32'(ia1) * 32'(ib1);
            tv1 = 32'(k * 3);
            tu1 = prod - tv1;
            itag1 = 4'(k);
            iv1 = 1'b1;
            tick();
            iv1 = 1'b0;
            acc = cyc;
            if (k > 0)
                chk("t6_interval", 32'(acc - last_acc), 32'd4);
            last_acc = acc;
            n = 0;
            while (!req1 && n < 20) begin
                tick();
                n++;
            end
            chk("t6_req_to", 32'(n < 20), 32'd1);
            chk("t6_res", res1, prod);
            chk("t6_tag", 32'(wtag1), 32'(k));
            ack1 = 1'b1;
            tick();
            ack1 = 1'b0;
            if (k == 14)
                chk("t6_cnt15", 32'(cnt1), 32'd15);
        end
        chk("t6_wrap", 32'(cnt1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
